// File: rtl/branch_ctrl.sv
// Branch/jump redirect controller for the EX stage: condition decode,
// IDLE/REDIRECT FSM, fetch redirect and IF/ID + ID/EX flush.
// Optional macro BRANCH_PERF_EN adds saturating br_count/taken_count outputs.
module branch_ctrl #(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             br_valid,
    input  logic             jump,
    input  logic [2:0]       funct3,
    input  logic             br_lt,
    input  logic             br_eq,
    input  logic [width-1:0] target,
    output logic             br_un,
    output logic             pc_sel,
    output logic [width-1:0] pc_target,
    output logic             flush_if_id,
    output logic             flush_id_ex,
`ifdef BRANCH_PERF_EN
    output logic [31:0]      br_count,
    output logic [31:0]      taken_count,
`endif
    output logic             illegal_br
);

    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] REDIRECT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [width-1:0] tgt_q, tgt_d;
    logic             ill_q, ill_d;
    logic             cond;
    logic             undef_f3;
    logic             taken;
    logic             decide;

    // Unsigned comparison for BLTU/BGEU
    assign br_un = funct3[2] & funct3[1];

    // Branch condition decode; 010/011 are undefined and never taken
    always_comb begin
        cond     = 1'b0;
        undef_f3 = 1'b0;
        unique case (funct3)
            3'b000:  cond = br_eq;
            3'b001:  cond = ~br_eq;
            3'b100:  cond = br_lt;
            3'b101:  cond = ~br_lt;
            3'b110:  cond = br_lt;
            3'b111:  cond = ~br_lt;
            default: undef_f3 = 1'b1;
        endcase
    end

    // A decision is only made from IDLE when the pipeline advances;
    // in REDIRECT the EX instruction is wrong-path and ignored.
    assign decide = (state_q == IDLE) & ~stall;
    assign taken  = jump | (br_valid & cond);

    // Next-state, redirect target capture and illegal-branch pulse
    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        ill_d   = decide & br_valid & ~jump & undef_f3;
        unique case (state_q)
            IDLE: begin
                if (decide && taken) begin
                    state_d = REDIRECT;
                    tgt_d   = {target[width-1:1], 1'b0};
                end
            end
            REDIRECT: begin
                if (!stall) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset aborts any redirect in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tgt_q   <= '0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            ill_q   <= ill_d;
        end
    end

    assign pc_sel      = (state_q == REDIRECT);
    assign flush_if_id = (state_q == REDIRECT);
    assign flush_id_ex = (state_q == REDIRECT);
    assign pc_target   = tgt_q;
    assign illegal_br  = ill_q;

`ifdef BRANCH_PERF_EN
    logic [31:0] brc_q, tkc_q;

    // Saturating counters of evaluated branches and taken redirects
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            brc_q <= '0;
            tkc_q <= '0;
        end else begin
            if (decide && br_valid && brc_q != 32'hFFFF_FFFF) begin
                brc_q <= brc_q + 32'd1;
            end
            if (decide && taken && tkc_q != 32'hFFFF_FFFF) begin
                tkc_q <= tkc_q + 32'd1;
            end
        end
    end

    assign br_count    = brc_q;
    assign taken_count = tkc_q;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Scoreboard bench for branch_ctrl: directed vectors push expected
// registered outputs; a negedge monitor pops and compares them.
module tb_branch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, br_valid, jump, br_lt, br_eq;
    logic [2:0]  funct3;
    logic [31:0] target;
    logic        br_un, pc_sel, flush_if_id, flush_id_ex, illegal_br;
    logic [31:0] pc_target;
`ifdef BRANCH_PERF_EN
    logic [31:0] br_count, taken_count;
`endif

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        int          due;
        logic        sel;
        logic [31:0] tgt;
        logic        ill;
    } exp_t;

    exp_t q[$];

    branch_ctrl #(.width(32)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .stall(stall),
        .br_valid(br_valid),
        .jump(jump),
        .funct3(funct3),
        .br_lt(br_lt),
        .br_eq(br_eq),
        .target(target),
        .br_un(br_un),
        .pc_sel(pc_sel),
        .pc_target(pc_target),
        .flush_if_id(flush_if_id),
        .flush_id_ex(flush_id_ex),
`ifdef BRANCH_PERF_EN
        .br_count(br_count),
        .taken_count(taken_count),
`endif
        .illegal_br(illegal_br)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Monitor: compare registered outputs against due expectations
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].due <= cyc) begin
                e = q.pop_front();
                chk("pc_sel", {31'b0, pc_sel}, {31'b0, e.sel});
                chk("flush_if_id", {31'b0, flush_if_id}, {31'b0, e.sel});
                chk("flush_id_ex", {31'b0, flush_id_ex}, {31'b0, e.sel});
                chk("pc_target", pc_target, e.tgt);
                chk("illegal_br", {31'b0, illegal_br}, {31'b0, e.ill});
            end
        end
    end

    // Drive one cycle of inputs; expectation is for after the next edge
    task automatic step(input logic st, input logic bv, input logic jp,
                        input logic [2:0] f3, input logic lt,
                        input logic eq, input logic [31:0] tg,
                        input logic xsel, input logic [31:0] xtgt,
                        input logic xill);
        exp_t e;
        @(posedge clk);
        #1;
        stall    = st;
        br_valid = bv;
        jump     = jp;
        funct3   = f3;
        br_lt    = lt;
        br_eq    = eq;
        target   = tg;
        #1;
        chk("br_un", {31'b0, br_un}, {31'b0, (f3 == 3'b110 || f3 == 3'b111)});
        e.due = cyc + 1;
        e.sel = xsel;
        e.tgt = xtgt;
        e.ill = xill;
        q.push_back(e);
    endtask

    task automatic idle_in();
        stall = 0; br_valid = 0; jump = 0;
        funct3 = 3'b000; br_lt = 0; br_eq = 0; target = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        idle_in();
        #12;
        chk("rst pc_sel", {31'b0, pc_sel}, 32'd0);
        chk("rst flush", {30'b0, flush_if_id, flush_id_ex}, 32'd0);
        chk("rst pc_target", pc_target, 32'd0);
        chk("rst illegal", {31'b0, illegal_br}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // BEQ taken, then back to IDLE
        step(0,1,0,3'b000,0,1,32'h104, 1,32'h104,0);
        step(0,0,0,3'b000,0,0,32'h0,   0,32'h104,0);
        // BGEU not taken
        step(0,1,0,3'b111,1,0,32'h500, 0,32'h104,0);
        // BNE taken, held by stall for 3 cycles, taken br ignored
        step(0,1,0,3'b001,0,0,32'h208, 1,32'h208,0);
        step(1,1,0,3'b000,0,1,32'h999, 1,32'h208,0);
        step(1,1,0,3'b000,0,1,32'h999, 1,32'h208,0);
        step(1,1,0,3'b000,0,1,32'h999, 1,32'h208,0);
        step(0,1,0,3'b000,0,1,32'h998, 0,32'h208,0);
        step(0,0,0,3'b000,0,0,32'h0,   0,32'h208,0);
        // JALR odd target
        step(0,0,1,3'b010,0,0,32'h2003,1,32'h2002,0);
        step(0,0,0,3'b000,0,0,32'h0,   0,32'h2002,0);
        // Undefined funct3: one-cycle pulse, no redirect
        step(0,1,0,3'b010,1,1,32'h300, 0,32'h2002,1);
        step(0,0,0,3'b000,0,0,32'h0,   0,32'h2002,0);
        // Stall in IDLE blocks a taken branch
        step(1,1,0,3'b000,0,1,32'h400, 0,32'h2002,0);
        // BLT taken
        step(0,1,0,3'b100,1,0,32'h404, 1,32'h404,0);
        step(0,0,0,3'b000,0,0,32'h0,   0,32'h404,0);
        // BLTU taken
        step(0,1,0,3'b110,1,0,32'h600, 1,32'h600,0);
        @(posedge clk);
        @(negedge clk);
        #1;
`ifdef BRANCH_PERF_EN
        chk("br_count", br_count, 32'd6);
        chk("taken_count", taken_count, 32'd5);
`endif
        // Reset mid-REDIRECT takes effect without a clock edge
        rst_n = 1'b0;
        idle_in();
        #1;
        chk("async pc_sel", {31'b0, pc_sel}, 32'd0);
        chk("async flush", {30'b0, flush_if_id, flush_id_ex}, 32'd0);
        chk("async pc_target", pc_target, 32'd0);
        #1;
        rst_n = 1'b1;
        // First decision after reset from IDLE: BGE taken
        step(0,1,0,3'b101,0,0,32'h700, 1,32'h700,0);
        step(0,0,0,3'b000,0,0,32'h0,   0,32'h700,0);
        @(posedge clk);
        @(negedge clk);
        #1;
`ifdef BRANCH_PERF_EN
        chk("br_count post-rst", br_count, 32'd1);
        chk("taken_count post-rst", taken_count, 32'd1);
`endif
        chk("scoreboard drained", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
